loadarch_state_loader: RTL and testbench

- Synthesizable successor to forced-register state injection for checkpoint restore.
- Accepts a packed architectural-state stream (PC, privilege, CSRs, XPRs, FPRs) per hart over a valid/ready interface.
- Issues ordered register-write strobes to each hart's state ports while holding those harts in reset.
- Releases each core's reset only after every hart is loaded and a programmable settle delay has elapsed.

---
 rtl/loadarch_state_loader_if.sv | 26 ++
 rtl/loadarch_state_loader.sv | 202 ++++++++++++++++++++
 tb/tb_loadarch_state_loader.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loadarch_state_loader_if.sv
// Stream-in and register-write bundle for loadarch_state_loader.
// slave = the loader, master = the stream source / write consumer.
interface loadarch_state_loader_if #(
    parameter int XLEN = 64
) ();
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_data;
    logic            in_last;

    logic            wr_valid;
    logic [3:0]      wr_hart;
    logic [1:0]      wr_kind;
    logic [7:0]      wr_idx;
    logic [XLEN-1:0] wr_data;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, wr_valid, wr_hart, wr_kind, wr_idx, wr_data
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, wr_valid, wr_hart, wr_kind, wr_idx, wr_data
    );
endinterface

// File: rtl/loadarch_state_loader.sv
// Checkpoint-restore loader: streams packed per-hart state into register-write strobes, then releases cores.
// Optional trailing XOR checksum word enabled by defining LOADARCH_CHECKSUM_EN.
module loadarch_state_loader #(
    parameter int NUM_HARTS     = 1,
    parameter int XLEN          = 64,
    parameter int NUM_CSR       = 16,
    parameter int NUM_XPR       = 32,
    parameter int NUM_FPR       = 32,
    parameter int RELEASE_DELAY = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    loadarch_state_loader_if.slave bus,
    output logic [NUM_HARTS-1:0]   core_reset,
    output logic                   done,
    output logic                   error
);
    localparam int OFF_CSR = 2;
    localparam int OFF_XPR = OFF_CSR + NUM_CSR;
    localparam int OFF_FPR = OFF_XPR + NUM_XPR - 1;
    localparam int WORDS   = OFF_FPR + NUM_FPR;
`ifdef LOADARCH_CHECKSUM_EN
    localparam int TOTAL   = WORDS * NUM_HARTS + 1;
`else
    localparam int TOTAL   = WORDS * NUM_HARTS;
`endif
    localparam int WW      = $clog2(WORDS + 1);
    localparam int TW      = $clog2(TOTAL + 1);

    localparam logic [WW-1:0] L_OFF_CSR  = WW'(OFF_CSR);
    localparam logic [WW-1:0] L_OFF_XPR  = WW'(OFF_XPR);
    localparam logic [WW-1:0] L_OFF_FPR  = WW'(OFF_FPR);
    localparam logic [WW-1:0] L_WORD_MAX = WW'(WORDS - 1);
    localparam logic [TW-1:0] L_LAST     = TW'(TOTAL - 1);
    localparam logic [8:0]    L_DELAY    = 9'(RELEASE_DELAY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                r_state;
    logic [WW-1:0]         r_word;
    logic [3:0]            r_hart;
    logic [TW-1:0]         r_cnt;
    logic [7:0]            r_delay;
    logic                  r_in_ready;
    logic                  r_wr_valid;
    logic [3:0]            r_wr_hart;
    logic [1:0]            r_wr_kind;
    logic [7:0]            r_wr_idx;
    logic [XLEN-1:0]       r_wr_data;
    logic [NUM_HARTS-1:0]  r_core_reset;
    logic                  r_done;
    logic                  r_error;
`ifdef LOADARCH_CHECKSUM_EN
    logic [XLEN-1:0]       r_xsum;
`endif

    logic       w_accept;
    logic       w_final;
    logic       w_ck_word;
    logic       w_fmt_ok;
    logic       w_write;
    logic [1:0] w_kind;
    logic [7:0] w_idx;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_final  = (r_cnt == L_LAST);
    assign w_fmt_ok = (bus.in_last == w_final);
`ifdef LOADARCH_CHECKSUM_EN
    assign w_ck_word = w_final;
`else
    assign w_ck_word = 1'b0;
`endif
    assign w_write  = w_accept && w_fmt_ok && !w_ck_word;

    // Map position within the hart's block onto architectural kind/index.
    always_comb begin
        w_kind = 2'd0;
        w_idx  = '0;
        if (r_word < L_OFF_CSR) begin
            w_kind = 2'd0;
            w_idx  = 8'(r_word);
        end else if (r_word < L_OFF_XPR) begin
            w_kind = 2'd1;
            w_idx  = 8'(r_word - L_OFF_CSR);
        end else if (r_word < L_OFF_FPR) begin
            w_kind = 2'd2;
            w_idx  = 8'(r_word - L_OFF_XPR + WW'(1));
        end else begin
            w_kind = 2'd3;
            w_idx  = 8'(r_word - L_OFF_FPR);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_word       <= '0;
            r_hart       <= '0;
            r_cnt        <= '0;
            r_delay      <= '0;
            r_in_ready   <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_hart    <= '0;
            r_wr_kind    <= '0;
            r_wr_idx     <= '0;
            r_wr_data    <= '0;
            r_core_reset <= '1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef LOADARCH_CHECKSUM_EN
            r_xsum       <= '0;
`endif
        end else begin
            r_wr_valid <= 1'b0;

            // Write strobe and counter advance share one condition across all build variants.
            if (w_write) begin
                r_wr_valid <= 1'b1;
                r_wr_hart  <= r_hart;
                r_wr_kind  <= w_kind;
                r_wr_idx   <= w_idx;
                r_wr_data  <= bus.in_data;
                if (r_word == L_WORD_MAX) begin
                    r_word <= '0;
                    r_hart <= r_hart + 4'd1;
                end else begin
                    r_word <= r_word + WW'(1);
                end
`ifdef LOADARCH_CHECKSUM_EN
                r_xsum <= r_xsum ^ bus.in_data;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b1;
                        r_word     <= '0;
                        r_hart     <= '0;
                        r_cnt      <= '0;
`ifdef LOADARCH_CHECKSUM_EN
                        r_xsum     <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + TW'(1);
                        if (!w_fmt_ok) begin
                            r_state    <= S_ERROR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else if (w_final) begin
                            r_in_ready <= 1'b0;
                            r_delay    <= '0;
`ifdef LOADARCH_CHECKSUM_EN
                            if (bus.in_data == r_xsum) begin
                                r_state <= S_SETTLE;
                            end else begin
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end
`else
                            r_state <= S_SETTLE;
`endif
                        end
                    end
                end
                S_SETTLE: begin
                    if ({1'b0, r_delay} + 9'd1 >= L_DELAY) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_core_reset <= '0;
                    end else begin
                        r_delay <= r_delay + 8'd1;
                    end
                end
                S_DONE, S_ERROR: begin
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_hart  = r_wr_hart;
    assign bus.wr_kind  = r_wr_kind;
    assign bus.wr_idx   = r_wr_idx;
    assign bus.wr_data  = r_wr_data;
    assign core_reset   = r_core_reset;
    assign done         = r_done;
    assign error        = r_error;
endmodule

// File: tb/tb_loadarch_state_loader.sv
// Self-checking bench for loadarch_state_loader: cycle-level behavioural model plus literal spot checks.
module tb_loadarch_state_loader;
    localparam int NH = 2;
    localparam int NC = 2;
    localparam int NX = 4;
    localparam int NF = 2;
    localparam int RD = 3;
    localparam int XL = 64;
    localparam int W  = 2 + NC + NX - 1 + NF;
    localparam int TS = W * NH;
`ifdef LOADARCH_CHECKSUM_EN
    localparam int T  = TS + 1;
    localparam int DONE_LAT = RD + 1;
`else
    localparam int T  = TS;
    localparam int DONE_LAT = RD;
`endif
    localparam int SETTLE_CYC = (RD == 0) ? 1 : RD;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [NH-1:0] core_reset;
    logic          done;
    logic          error;

    loadarch_state_loader_if #(.XLEN(XL)) bus ();

    loadarch_state_loader #(
        .NUM_HARTS    (NH),
        .XLEN         (XL),
        .NUM_CSR      (NC),
        .NUM_XPR      (NX),
        .NUM_FPR      (NF),
        .RELEASE_DELAY(RD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .core_reset(core_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-word-position kind/index, built by walking the documented word order.
    int kind_tab[W];
    int idx_tab[W];

    function automatic void build_tab();
        int n;
        n = 0;
        kind_tab[n] = 0; idx_tab[n] = 0; n++;
        kind_tab[n] = 0; idx_tab[n] = 1; n++;
        for (int c = 0; c < NC; c++) begin kind_tab[n] = 1; idx_tab[n] = c; n++; end
        for (int x = 1; x < NX; x++) begin kind_tab[n] = 2; idx_tab[n] = x; n++; end
        for (int f = 0; f < NF; f++) begin kind_tab[n] = 3; idx_tab[n] = f; n++; end
    endfunction

    // Model state
    bit          m_armed   = 1'b0;
    bit          m_loading = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_error   = 1'b0;
    int          m_settle  = 0;
    int          m_acc     = 0;
    logic [63:0] m_xsum    = '0;
    bit          m_final;
    bit          m_ckw;
    bit          e_wv      = 1'b0;
    int          e_hart, e_kind, e_idx;
    logic [63:0] e_data;

    initial forever begin
        @(posedge clock);
        e_wv = 1'b0;
        if (reset === 1'b0) begin
            m_armed   = 1'b1;
            m_loading = 1'b0;
            m_done    = 1'b0;
            m_error   = 1'b0;
            m_settle  = 0;
            m_acc     = 0;
            m_xsum    = '0;
        end else if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) m_done = 1'b1;
        end else if (m_loading) begin
            if (bus.in_valid === 1'b1) begin
                m_final = (m_acc == T - 1);
                m_ckw   = 1'b0;
`ifdef LOADARCH_CHECKSUM_EN
                m_ckw   = m_final;
`endif
                if (bus.in_last !== m_final) begin
                    m_loading = 1'b0;
                    m_error   = 1'b1;
                end else if (m_ckw) begin
                    m_loading = 1'b0;
                    if (bus.in_data === m_xsum) m_settle = SETTLE_CYC;
                    else m_error = 1'b1;
                end else begin
                    e_wv   = 1'b1;
                    e_hart = m_acc / W;
                    e_kind = kind_tab[m_acc % W];
                    e_idx  = idx_tab[m_acc % W];
                    e_data = bus.in_data;
                    m_xsum = m_xsum ^ bus.in_data;
                    if (m_final) begin
                        m_loading = 1'b0;
                        m_settle  = SETTLE_CYC;
                    end
                end
                m_acc++;
            end
        end else if (!m_done && !m_error && start === 1'b1) begin
            m_loading = 1'b1;
            m_acc     = 0;
            m_xsum    = '0;
        end
    end

    typedef struct {
        int          hart;
        int          kind;
        int          idx;
        logic [63:0] data;
    } wr_t;
    wr_t wlog[$];
    int  cycle       = 0;
    int  last_wr_cyc = -1;
    int  done_cyc    = -1;
    bit  prev_done   = 1'b0;

    initial forever begin
        @(negedge clock);
        cycle++;
        if (m_armed) begin
            chk("in_ready",   bus.in_ready, m_loading);
            chk("wr_valid",   bus.wr_valid, e_wv);
            if (e_wv) begin
                chk("wr_hart", bus.wr_hart, e_hart);
                chk("wr_kind", bus.wr_kind, e_kind);
                chk("wr_idx",  bus.wr_idx,  e_idx);
                chk("wr_data", bus.wr_data, e_data);
            end
            chk("core_reset", core_reset, m_done ? 64'd0 : 64'd3);
            chk("done",       done,  m_done);
            chk("error",      error, m_error);
        end
        if (bus.wr_valid === 1'b1) begin
            wlog.push_back('{int'(bus.wr_hart), int'(bus.wr_kind), int'(bus.wr_idx), bus.wr_data});
            last_wr_cyc = cycle;
        end
        if (done === 1'b1 && !prev_done) done_cyc = cycle;
        prev_done = (done === 1'b1);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},   bus.in_ready, 0);
        chk({tag, "_wr_valid"},   bus.wr_valid, 0);
        chk({tag, "_wr_fields"},  {bus.wr_hart, bus.wr_kind, bus.wr_idx}, 0);
        chk({tag, "_wr_data"},    bus.wr_data, 0);
        chk({tag, "_core_reset"}, core_reset, 3);
        chk({tag, "_done"},       done, 0);
        chk({tag, "_error"},      error, 0);
    endtask

    // Sends words 1..nwords; in_last on word last_at (0 = never). Word T carries the checksum when enabled.
    task automatic send_stream(input int nwords, input int last_at, input bit gaps, input bit rnd, input bit bad_ck);
        logic [63:0] x;
        logic [63:0] d;
        x = '0;
        for (int i = 1; i <= nwords; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = {$urandom, $urandom};
                    bus.in_last  = 1'($urandom_range(0, 1));
                    cyc();
                end
            end
            d = rnd ? {$urandom, $urandom} : 64'(i);
`ifdef LOADARCH_CHECKSUM_EN
            if (i == T) d = x ^ (bad_ck ? 64'd1 : 64'd0);
`else
            if (bad_ck) d = d;
`endif
            x = x ^ d;
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_last  = (i == last_at);
            cyc();
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    initial begin
        build_tab();
        reset        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (2) cyc();
        check_reset_vals("por");
        reset = 1'b1;
        cyc();

        // Nominal load; words offered in IDLE must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hdead_beef;
        repeat (2) cyc();
        bus.in_valid = 1'b0;
        wlog.delete();
        done_cyc = -1;
        pulse_start();
        send_stream(T, T, 1'b0, 1'b0, 1'b0);
        repeat (8) cyc();
        chk("nom_writes", wlog.size(), 18);
        if (wlog.size() >= 10) begin
            chk("nom_w10_hart", wlog[9].hart, 1);
            chk("nom_w10_kind", wlog[9].kind, 0);
            chk("nom_w10_idx",  wlog[9].idx,  0);
            chk("nom_w10_data", wlog[9].data, 10);
            chk("nom_w5_hart",  wlog[4].hart, 0);
            chk("nom_w5_kind",  wlog[4].kind, 2);
            chk("nom_w5_idx",   wlog[4].idx,  1);
        end
        chk("nom_done_latency", done_cyc - last_wr_cyc, DONE_LAT);
        chk("nom_done",       done, 1);
        chk("nom_core_reset", core_reset, 0);
        pulse_start();
        repeat (4) cyc();
        chk("nom_done_hold", done, 1);

        // Randomized gaps and data.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            wlog.delete();
            pulse_start();
            send_stream(T, T, 1'b1, 1'b1, 1'b0);
            repeat (8) cyc();
            chk("gap_writes", wlog.size(), 18);
            chk("gap_done",   done, 1);
        end

        // Early in_last on word 7.
        do_reset();
        wlog.delete();
        pulse_start();
        send_stream(7, 7, 1'b0, 1'b1, 1'b0);
        repeat (100) cyc();
        pulse_start();
        repeat (10) cyc();
        chk("early_writes",     wlog.size(), 6);
        chk("early_error",      error, 1);
        chk("early_core_reset", core_reset, 3);
        chk("early_in_ready",   bus.in_ready, 0);

        // Missing in_last on the final word.
        do_reset();
        wlog.delete();
        pulse_start();
        send_stream(T, 0, 1'b0, 1'b1, 1'b0);
        repeat (20) cyc();
        chk("miss_writes", wlog.size(), T - 1);
        chk("miss_error",  error, 1);
        chk("miss_done",   done, 0);

        // Reset mid-load, then a clean reload.
        do_reset();
        pulse_start();
        send_stream(12, 0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        cyc();
        check_reset_vals("midrst");
        reset = 1'b1;
        cyc();
        wlog.delete();
        pulse_start();
        send_stream(T, T, 1'b1, 1'b1, 1'b0);
        repeat (8) cyc();
        chk("midrst_writes", wlog.size(), 18);
        chk("midrst_done",   done, 1);

`ifdef LOADARCH_CHECKSUM_EN
        // Corrupted checksum word.
        do_reset();
        wlog.delete();
        pulse_start();
        send_stream(T, T, 1'b0, 1'b1, 1'b1);
        repeat (10) cyc();
        chk("badck_writes", wlog.size(), 18);
        chk("badck_error",  error, 1);
        chk("badck_done",   done, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
